// File: rtl/day5_odd_counter.sv
// day5_odd_counter: free-running odd-number counter (START, START+2, ... wrapping mod 2^WIDTH); ports clk, reset (sync active-high), cnt_o (registered count)
module day5_odd_counter #(
  parameter int unsigned           WIDTH = 8,
  parameter logic [WIDTH-1:0]      START = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = reset ? START : cnt_q + WIDTH'(2);
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: tb/tb_day5_odd_counter.sv
// tb_day5_odd_counter: directed self-checking bench for day5_odd_counter
module tb_day5_odd_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cnt_o;
  int         tests = 0;
  int         fails = 0;

  day5_odd_counter dut (.clk(clk), .reset(reset), .cnt_o(cnt_o));

  always #5 clk = ~clk;

  task automatic step(input logic r);
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1);
    tests++;
    if (cnt_o !== 8'd1) begin fails++; $display("FAIL reset_val got %0d want 1", cnt_o); end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd3) begin fails++; $display("FAIL reset_first got %0d want 3", cnt_o); end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd5) begin fails++; $display("FAIL reset_second got %0d want 5", cnt_o); end
  endtask

  task automatic test_run;
    step(1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      tests++;
      if (cnt_o !== 8'(3 + 2 * i) || cnt_o[0] !== 1'b1) begin
        fails++;
        $display("FAIL run_seq step %0d got %0d want %0d", i, cnt_o, 3 + 2 * i);
      end
    end
  endtask

  task automatic test_wrap;
    step(1'b1);
    for (int i = 0; i < 127; i++) begin
      step(1'b0);
      tests++;
      if (cnt_o[0] !== 1'b1) begin fails++; $display("FAIL wrap_lsb step %0d got %0d want odd", i, cnt_o); end
    end
    tests++;
    if (cnt_o !== 8'd255) begin fails++; $display("FAIL wrap_top got %0d want 255", cnt_o); end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd1) begin fails++; $display("FAIL wrap_to_one got %0d want 1", cnt_o); end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd3) begin fails++; $display("FAIL wrap_then_three got %0d want 3", cnt_o); end
  endtask

  task automatic test_mid_reset;
    step(1'b1);
    for (int i = 0; i < 38; i++) step(1'b0);
    tests++;
    if (cnt_o !== 8'd77) begin fails++; $display("FAIL mid_reach77 got %0d want 77", cnt_o); end
    step(1'b1);
    tests++;
    if (cnt_o !== 8'd1) begin fails++; $display("FAIL mid_reset got %0d want 1", cnt_o); end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd3) begin fails++; $display("FAIL mid_resume3 got %0d want 3", cnt_o); end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd5) begin fails++; $display("FAIL mid_resume5 got %0d want 5", cnt_o); end
  endtask

  task automatic test_held_reset;
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      tests++;
      if (cnt_o !== 8'd1) begin fails++; $display("FAIL held_reset edge %0d got %0d want 1", i, cnt_o); end
    end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd3) begin fails++; $display("FAIL held_release got %0d want 3", cnt_o); end
  endtask

  task automatic test_reset_at_wrap;
    step(1'b1);
    for (int i = 0; i < 127; i++) step(1'b0);
    tests++;
    if (cnt_o !== 8'd255) begin fails++; $display("FAIL prec_top got %0d want 255", cnt_o); end
    step(1'b1);
    tests++;
    if (cnt_o !== 8'd1) begin fails++; $display("FAIL prec_reset got %0d want 1", cnt_o); end
    step(1'b0);
    tests++;
    if (cnt_o !== 8'd3) begin fails++; $display("FAIL prec_after got %0d want 3", cnt_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_run;
    test_wrap;
    test_mid_reset;
    test_held_reset;
    test_reset_at_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
